exec_writeback_unit: RTL and testbench

//  Downstream end of the issue-stage protocol: consumes the four issued-instruction lanes
//  (out_N_*) and returns completion writebacks (ins_back_N / ins_back_N_des) to the issue stage.

---
 rtl/exwb_pkg.sv | 30 +++
 rtl/exec_writeback_unit_if.sv | 25 ++
 rtl/exwb_lane.sv | 90 +++++++++
 rtl/exec_writeback_unit.sv | 71 +++++++
 tb/tb_exec_writeback_unit.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/exwb_pkg.sv
// Shared widths, slot record and latency decode for the execute/writeback unit.
package exwb_pkg;

  localparam int DES_W = 4;
  localparam int OP_W  = 4;
  localparam int BR_W  = 3;

  typedef struct packed {
    logic             vld;
    logic [DES_W-1:0] des;
    logic [BR_W-1:0]  br;
  } slot_t;

  // op[3:2] selects the latency class; the low opcode bits do not affect timing.
  function automatic int lat_of_op(input logic [OP_W-1:0] op, input int mul_lat);
    case (op[3:2])
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 3;
      default: return mul_lat;
    endcase
  endfunction

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/exec_writeback_unit_if.sv
// Issue-lane / writeback bundle between the issue stage (master) and the execute/writeback unit (slave).
interface exec_writeback_unit_if;
  import exwb_pkg::*;

  logic [3:0]                 out_vld;
  logic [3:0][DES_W-1:0]      out_des;
  logic [3:0][OP_W-1:0]       out_op;
  logic [3:0][BR_W-1:0]       out_branch;
  logic                       flush_en;
  logic [BR_W-1:0]            flush_id;
  logic [3:0]                 ins_back;
  logic [3:0][DES_W-1:0]      ins_back_des;
  logic                       busy;

  modport master (
    output out_vld, out_des, out_op, out_branch, flush_en, flush_id,
    input  ins_back, ins_back_des, busy
  );

  modport slave (
    input  out_vld, out_des, out_op, out_branch, flush_en, flush_id,
    output ins_back, ins_back_des, busy
  );

endinterface

// File: rtl/exwb_lane.sv
// One lane: D-slot completion pipeline with latency-directed insert and branch-tag flush.
// Writeback comes straight from the slot[0] flop; the lane never stalls its producer.
module exwb_lane
  import exwb_pkg::*;
#(
  parameter int D = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic [DES_W-1:0] in_des,
  input  logic [OP_W-1:0]  in_op,
  input  logic [BR_W-1:0]  in_br,
  input  logic             flush_en,
  input  logic [BR_W-1:0]  flush_id,
  output logic             wb_vld,
  output logic [DES_W-1:0] wb_des,
  output logic             busy,
  output logic [7:0]       kill_num
);

  slot_t slot_q [D];
  slot_t slot_d [D];
  logic  busy_d;
  logic  in_kill;
  int    lat;
  int    ins_idx;
  logic  found;

  always_comb begin
    slot_t sh;
    kill_num = '0;
    ins_idx  = 0;
    found    = 1'b0;
    busy_d   = 1'b0;
    lat      = lat_of_op(in_op, D);
    sh       = '0;

    // Shift toward slot[0]; killed slots are cleared whole so des reads 0 when idle.
    for (int i = 0; i < D - 1; i++) begin
      sh = slot_q[i+1];
      if (flush_en && sh.vld && (sh.br == flush_id)) begin
        sh       = '0;
        kill_num = kill_num + 8'd1;
      end
      slot_d[i] = sh;
    end
    slot_d[D-1] = '0;

    in_kill = in_vld && flush_en && (in_br == flush_id);
    if (in_kill) begin
      kill_num = kill_num + 8'd1;
    end

    // Lowest free slot at or above L-1; slot[D-1] is always free so a spot exists.
    if (in_vld && !in_kill) begin
      for (int i = D - 1; i >= 0; i--) begin
        if ((i >= lat - 1) && !slot_d[i].vld) begin
          ins_idx = i;
          found   = 1'b1;
        end
      end
    end
    if (found) begin
      slot_d[ins_idx] = '{vld: 1'b1, des: in_des, br: in_br};
    end

    for (int i = 0; i < D; i++) begin
      busy_d = busy_d | slot_d[i].vld;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < D; i++) begin
        slot_q[i] <= '0;
      end
      busy <= 1'b0;
    end else begin
      for (int i = 0; i < D; i++) begin
        slot_q[i] <= slot_d[i];
      end
      busy <= busy_d;
    end
  end

  assign wb_vld = slot_q[0].vld;
  assign wb_des = slot_q[0].des;

endmodule

// File: rtl/exec_writeback_unit.sv
// Four-lane execute/writeback model returning completions to the issue stage; never back-pressures.
// Optional perf counters (done_cnt/kill_cnt) are built when EXWB_PERF_CNT_EN is defined.
module exec_writeback_unit
  import exwb_pkg::*;
#(
  parameter int MUL_LAT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  exec_writeback_unit_if.slave bus
`ifdef EXWB_PERF_CNT_EN
  ,
  output logic [15:0]          done_cnt,
  output logic [15:0]          kill_cnt
`endif
);

  logic [3:0]            wb_vld;
  logic [3:0][DES_W-1:0] wb_des;
  logic [3:0]            lane_busy;
  logic [3:0][7:0]       lane_kill;

  for (genvar l = 0; l < 4; l++) begin : g_lane
    exwb_lane #(
      .D(MUL_LAT)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .in_vld   (bus.out_vld[l]),
      .in_des   (bus.out_des[l]),
      .in_op    (bus.out_op[l]),
      .in_br    (bus.out_branch[l]),
      .flush_en (bus.flush_en),
      .flush_id (bus.flush_id),
      .wb_vld   (wb_vld[l]),
      .wb_des   (wb_des[l]),
      .busy     (lane_busy[l]),
      .kill_num (lane_kill[l])
    );
  end

  assign bus.ins_back     = wb_vld;
  assign bus.ins_back_des = wb_des;
  assign bus.busy         = |lane_busy;

`ifdef EXWB_PERF_CNT_EN
  logic [15:0] done_inc;
  logic [15:0] kill_inc;

  always_comb begin
    done_inc = '0;
    kill_inc = '0;
    for (int l = 0; l < 4; l++) begin
      done_inc = done_inc + {15'd0, wb_vld[l]};
      kill_inc = kill_inc + {8'd0, lane_kill[l]};
    end
  end

  // done counts pulses as they become visible; kill counts at the killing edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_cnt <= '0;
      kill_cnt <= '0;
    end else begin
      done_cnt <= sat_add16(done_cnt, done_inc);
      kill_cnt <= sat_add16(kill_cnt, kill_inc);
    end
  end
`endif

endmodule

// File: tb/tb_exec_writeback_unit.sv
// Directed bench for exec_writeback_unit: latency classes, delayed insert, flush and reset abort.
module tb_exec_writeback_unit;
  import exwb_pkg::*;

  logic clk;
  logic rst;
  int   vectors;
  int   errs;

  exec_writeback_unit_if bus();

`ifdef EXWB_PERF_CNT_EN
  logic [15:0] done_cnt;
  logic [15:0] kill_cnt;
`endif

  exec_writeback_unit #(
    .MUL_LAT(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
`ifdef EXWB_PERF_CNT_EN
    ,
    .done_cnt (done_cnt),
    .kill_cnt (kill_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    bus.out_vld    = '0;
    bus.out_des    = '0;
    bus.out_op     = '0;
    bus.out_branch = '0;
    bus.flush_en   = 1'b0;
    bus.flush_id   = '0;
  endtask

  task automatic issue(input int lane, input logic [3:0] des, input logic [3:0] op,
                       input logic [2:0] br);
    bus.out_vld[lane]    = 1'b1;
    bus.out_des[lane]    = des;
    bus.out_op[lane]     = op;
    bus.out_branch[lane] = br;
  endtask

  // Advance one edge and settle just after it, so outputs show the new cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors = 0;
    errs    = 0;
    rst     = 1'b0;
    clear_in();
    step();
    chk("rst_ins_back", {28'd0, bus.ins_back}, 32'h0);
    chk("rst_des", {16'd0, bus.ins_back_des}, 32'h0);
    chk("rst_busy", {31'd0, bus.busy}, 32'h0);
`ifdef EXWB_PERF_CNT_EN
    chk("rst_kill_cnt", {16'd0, kill_cnt}, 32'h0);
`endif
    rst = 1'b1;
    step();

    // 1: single-cycle op on lane 1
    issue(0, 4'd5, 4'h0, 3'd0);
    step();
    clear_in();
    chk("t1_back", {28'd0, bus.ins_back}, 32'h1);
    chk("t1_des", {28'd0, bus.ins_back_des[0]}, 32'h5);
    chk("t1_busy", {31'd0, bus.busy}, 32'h1);
    step();
    chk("t1_back_off", {28'd0, bus.ins_back}, 32'h0);
    chk("t1_busy_off", {31'd0, bus.busy}, 32'h0);

    // 2: all four latency classes issued together
    issue(0, 4'd1, 4'h0, 3'd0);
    issue(1, 4'd2, 4'h4, 3'd0);
    issue(2, 4'd3, 4'h8, 3'd0);
    issue(3, 4'd4, 4'hC, 3'd0);
    step();
    clear_in();
    chk("t2_k1", {28'd0, bus.ins_back}, 32'h1);
    chk("t2_k1_des", {28'd0, bus.ins_back_des[0]}, 32'h1);
    step();
    chk("t2_k2", {28'd0, bus.ins_back}, 32'h2);
    chk("t2_k2_des", {28'd0, bus.ins_back_des[1]}, 32'h2);
    step();
    chk("t2_k3", {28'd0, bus.ins_back}, 32'h4);
    chk("t2_k3_des", {28'd0, bus.ins_back_des[2]}, 32'h3);
    step();
    chk("t2_k4", {28'd0, bus.ins_back}, 32'h8);
    chk("t2_k4_des", {28'd0, bus.ins_back_des[3]}, 32'h4);
    step();
    chk("t2_k5", {28'd0, bus.ins_back}, 32'h0);
    chk("t2_busy", {31'd0, bus.busy}, 32'h0);

    // 3: lane 2 slot collision pushes the short op one cycle later
    issue(1, 4'd3, 4'hC, 3'd0);
    step();
    clear_in();
    chk("t3_k1", {28'd0, bus.ins_back}, 32'h0);
    step();
    issue(1, 4'd7, 4'h4, 3'd0);
    step();
    clear_in();
    chk("t3_k3", {28'd0, bus.ins_back}, 32'h0);
    step();
    chk("t3_k4", {28'd0, bus.ins_back}, 32'h2);
    chk("t3_k4_des", {28'd0, bus.ins_back_des[1]}, 32'h3);
    step();
    chk("t3_k5", {28'd0, bus.ins_back}, 32'h2);
    chk("t3_k5_des", {28'd0, bus.ins_back_des[1]}, 32'h7);
    step();
    chk("t3_k6", {28'd0, bus.ins_back}, 32'h0);

    // 4: in-flight flush on lane 3, lane 4 with another tag survives
    issue(2, 4'd9, 4'h8, 3'd2);
    issue(3, 4'd11, 4'h8, 3'd1);
    step();
    clear_in();
    bus.flush_en = 1'b1;
    bus.flush_id = 3'd2;
    chk("t4_k1", {28'd0, bus.ins_back}, 32'h0);
    step();
    clear_in();
    chk("t4_k2", {28'd0, bus.ins_back}, 32'h0);
    step();
    chk("t4_k3", {28'd0, bus.ins_back}, 32'h8);
    chk("t4_k3_des3", {28'd0, bus.ins_back_des[3]}, 32'hB);
    chk("t4_k3_des2", {28'd0, bus.ins_back_des[2]}, 32'h0);
`ifdef EXWB_PERF_CNT_EN
    chk("t4_kill_cnt", {16'd0, kill_cnt}, 32'h1);
`endif
    step();
    chk("t4_busy", {31'd0, bus.busy}, 32'h0);

    // 5: incoming op killed by a same-cycle flush; unrelated tag proceeds
    bus.flush_en = 1'b1;
    bus.flush_id = 3'd6;
    issue(0, 4'd13, 4'h0, 3'd6);
    issue(1, 4'd14, 4'h0, 3'd5);
    step();
    clear_in();
    chk("t5_back", {28'd0, bus.ins_back}, 32'h2);
    chk("t5_des", {28'd0, bus.ins_back_des[1]}, 32'hE);
    chk("t5_des0", {28'd0, bus.ins_back_des[0]}, 32'h0);
`ifdef EXWB_PERF_CNT_EN
    chk("t5_kill_cnt", {16'd0, kill_cnt}, 32'h2);
`endif
    step();
    chk("t5_back_off", {28'd0, bus.ins_back}, 32'h0);

    // 6: async reset with four multiplies in flight
    issue(0, 4'd1, 4'hC, 3'd0);
    issue(1, 4'd2, 4'hC, 3'd0);
    issue(2, 4'd3, 4'hC, 3'd0);
    issue(3, 4'd4, 4'hC, 3'd0);
    step();
    clear_in();
    chk("t6_busy_pre", {31'd0, bus.busy}, 32'h1);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_back_rst", {28'd0, bus.ins_back}, 32'h0);
    chk("t6_des_rst", {16'd0, bus.ins_back_des}, 32'h0);
    chk("t6_busy_rst", {31'd0, bus.busy}, 32'h0);
    step();
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("t6_no_wb", {28'd0, bus.ins_back}, 32'h0);
    end
    chk("t6_busy_end", {31'd0, bus.busy}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
